mem_issue_queue: RTL and testbench

In-order issue buffer between dispatch and `memblock`. It accepts load/store micro-ops from dispatch with a valid/ready handshake and holds them in a small circular FIFO. It presents the oldest entry to `memblock` over that stage's `instr_valid`/`instr_ready` handshake. On a redirect it drops every held or arriving micro-op younger than the flushing ROB index, so `memblock` only ever sees surviving work.

---
 rtl/mem_issue_queue_pkg.sv | 31 +++
 rtl/mem_issue_queue.sv | 155 +++++++++++++++
 tb/tb_mem_issue_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_issue_queue_pkg.sv
// Shared types and the ROB age rule for the memory issue path.
// memblock uses the same rob_is_younger() so both stages agree on what a redirect kills.
package mem_issue_queue_pkg;

  localparam int unsigned PREG_W       = 7;
  localparam int unsigned XLEN         = 64;
  localparam int unsigned LS_SIZE_W    = 4;
  localparam int unsigned ROB_SIZE_LOG = 6;

  typedef struct packed {
    logic [PREG_W-1:0]       prd;
    logic                    is_load;
    logic                    is_store;
    logic                    is_unsigned;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         src1;
    logic [XLEN-1:0]         src2;
    logic [LS_SIZE_W-1:0]    ls_size;
    logic                    robidx_flag;
    logic [ROB_SIZE_LOG-1:0] robidx;
  } mem_iq_entry_t;

  // Entry is strictly younger than the flush point; the flag bit resolves ROB index wrap.
  function automatic logic rob_is_younger(input logic                    flush_flag,
                                          input logic [ROB_SIZE_LOG-1:0] flush_idx,
                                          input logic                    flag,
                                          input logic [ROB_SIZE_LOG-1:0] idx);
    return (flush_flag ^ flag) ^ (flush_idx < idx);
  endfunction

endpackage

// File: rtl/mem_issue_queue.sv
// In-order load/store issue FIFO between dispatch and memblock.
// Redirects trim the younger tail of the queue and can veto the head and the incoming micro-op.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,

  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [PREG_W-1:0]       enq_prd,
  input  logic                    enq_is_load,
  input  logic                    enq_is_store,
  input  logic                    enq_is_unsigned,
  input  logic [XLEN-1:0]         enq_imm,
  input  logic [XLEN-1:0]         enq_src1,
  input  logic [XLEN-1:0]         enq_src2,
  input  logic [LS_SIZE_W-1:0]    enq_ls_size,
  input  logic                    enq_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] enq_robidx,

  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [PREG_W-1:0]       deq_prd,
  output logic                    deq_is_load,
  output logic                    deq_is_store,
  output logic                    deq_is_unsigned,
  output logic [XLEN-1:0]         deq_imm,
  output logic [XLEN-1:0]         deq_src1,
  output logic [XLEN-1:0]         deq_src2,
  output logic [LS_SIZE_W-1:0]    deq_ls_size,
  output logic                    deq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] deq_robidx,

  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,

  output logic [PTR_W:0]          count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  mem_iq_entry_t  entries [DEPTH];
  mem_iq_entry_t  enq_entry;
  mem_iq_entry_t  head_entry;
  mem_iq_entry_t  deq_entry;

  logic [PTR_W:0] head;
  logic [PTR_W:0] tail;
  logic [PTR_W:0] head_nxt;
  logic [PTR_W:0] tail_nxt;
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] survivors;
  logic [PTR_W:0] scan_ptr;
  logic           scan_alive;

  logic           nonempty;
  logic           head_killed;
  logic           enq_killed;
  logic           enq_fire;
  logic           deq_fire;

  assign enq_entry = '{
    prd:         enq_prd,
    is_load:     enq_is_load,
    is_store:    enq_is_store,
    is_unsigned: enq_is_unsigned,
    imm:         enq_imm,
    src1:        enq_src1,
    src2:        enq_src2,
    ls_size:     enq_ls_size,
    robidx_flag: enq_robidx_flag,
    robidx:      enq_robidx
  };

  assign count      = tail - head;
  assign nonempty   = (count != '0);
  assign head_entry = entries[head[PTR_W-1:0]];

  // Redirect vetoes: a killed head is hidden this cycle, a killed arrival is never written.
  assign head_killed = flush_valid &
                       rob_is_younger(flush_robidx_flag, flush_robidx,
                                      head_entry.robidx_flag, head_entry.robidx);
  assign enq_killed  = flush_valid &
                       rob_is_younger(flush_robidx_flag, flush_robidx,
                                      enq_robidx_flag, enq_robidx);

  assign enq_ready = (count != DEPTH_CNT);
  assign enq_fire  = enq_valid & enq_ready & ~enq_killed;
  assign deq_valid = nonempty & ~head_killed;
  assign deq_fire  = deq_valid & deq_ready;

  // Count the leading run of live entries that survive the flush; killed ones form a tail suffix.
  always_comb begin
    survivors  = '0;
    scan_alive = 1'b1;
    scan_ptr   = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_ptr = head + (PTR_W+1)'(i);
      if (scan_alive && ((PTR_W+1)'(i) < count) &&
          !rob_is_younger(flush_robidx_flag, flush_robidx,
                          entries[scan_ptr[PTR_W-1:0]].robidx_flag,
                          entries[scan_ptr[PTR_W-1:0]].robidx)) begin
        survivors = survivors + (PTR_W+1)'(1);
      end else begin
        scan_alive = 1'b0;
      end
    end
  end

  // A flush rewinds the write point to just past the survivors; a popped survivor is already in head_nxt.
  always_comb begin
    head_nxt = head + (PTR_W+1)'(deq_fire);
    wr_ptr   = tail;
    if (flush_valid) begin
      wr_ptr = head + survivors;
    end
    tail_nxt = wr_ptr + (PTR_W+1)'(enq_fire);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

  // Payload storage carries no reset; the pointers alone define what is live.
  always_ff @(posedge clock) begin
    if (reset_n && enq_fire) begin
      entries[wr_ptr[PTR_W-1:0]] <= enq_entry;
    end
  end

  assign deq_entry = nonempty ? head_entry : '0;

  assign deq_prd         = deq_entry.prd;
  assign deq_is_load     = deq_entry.is_load;
  assign deq_is_store    = deq_entry.is_store;
  assign deq_is_unsigned = deq_entry.is_unsigned;
  assign deq_imm         = deq_entry.imm;
  assign deq_src1        = deq_entry.src1;
  assign deq_src2        = deq_entry.src2;
  assign deq_ls_size     = deq_entry.ls_size;
  assign deq_robidx_flag = deq_entry.robidx_flag;
  assign deq_robidx      = deq_entry.robidx;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: directed scenarios plus a randomized run
// against a queue-based model that judges age by modular distance of the 7-bit ROB tag.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    enq_valid;
  logic                    enq_ready;
  logic [PREG_W-1:0]       enq_prd;
  logic                    enq_is_load;
  logic                    enq_is_store;
  logic                    enq_is_unsigned;
  logic [XLEN-1:0]         enq_imm;
  logic [XLEN-1:0]         enq_src1;
  logic [XLEN-1:0]         enq_src2;
  logic [LS_SIZE_W-1:0]    enq_ls_size;
  logic                    enq_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] enq_robidx;
  logic                    deq_valid;
  logic                    deq_ready;
  logic [PREG_W-1:0]       deq_prd;
  logic                    deq_is_load;
  logic                    deq_is_store;
  logic                    deq_is_unsigned;
  logic [XLEN-1:0]         deq_imm;
  logic [XLEN-1:0]         deq_src1;
  logic [XLEN-1:0]         deq_src2;
  logic [LS_SIZE_W-1:0]    deq_ls_size;
  logic                    deq_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] deq_robidx;
  logic                    flush_valid;
  logic                    flush_robidx_flag;
  logic [ROB_SIZE_LOG-1:0] flush_robidx;
  logic [PTR_W:0]          count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_prd(enq_prd),
    .enq_is_load(enq_is_load), .enq_is_store(enq_is_store), .enq_is_unsigned(enq_is_unsigned),
    .enq_imm(enq_imm), .enq_src1(enq_src1), .enq_src2(enq_src2), .enq_ls_size(enq_ls_size),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_prd(deq_prd),
    .deq_is_load(deq_is_load), .deq_is_store(deq_is_store), .deq_is_unsigned(deq_is_unsigned),
    .deq_imm(deq_imm), .deq_src1(deq_src1), .deq_src2(deq_src2), .deq_ls_size(deq_ls_size),
    .deq_robidx_flag(deq_robidx_flag), .deq_robidx(deq_robidx),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
    .flush_robidx(flush_robidx), .count(count)
  );

  // Younger means the entry tag lies 1..64 steps after the flush tag in the 128-entry tag space.
  function automatic logic younger_m(input logic [6:0] ft, input logic [6:0] et);
    logic [6:0] d;
    d = et - ft;
    return (d != 7'd0) && (d <= 7'd64);
  endfunction

  function automatic mem_iq_entry_t enq_view();
    mem_iq_entry_t e;
    e.prd = enq_prd; e.is_load = enq_is_load; e.is_store = enq_is_store;
    e.is_unsigned = enq_is_unsigned; e.imm = enq_imm; e.src1 = enq_src1; e.src2 = enq_src2;
    e.ls_size = enq_ls_size; e.robidx_flag = enq_robidx_flag; e.robidx = enq_robidx;
    return e;
  endfunction

  function automatic mem_iq_entry_t deq_view();
    mem_iq_entry_t e;
    e.prd = deq_prd; e.is_load = deq_is_load; e.is_store = deq_is_store;
    e.is_unsigned = deq_is_unsigned; e.imm = deq_imm; e.src1 = deq_src1; e.src2 = deq_src2;
    e.ls_size = deq_ls_size; e.robidx_flag = deq_robidx_flag; e.robidx = deq_robidx;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0; deq_ready = 1'b0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0;
  endtask

  task automatic set_flush(input logic v, input logic fl, input logic [ROB_SIZE_LOG-1:0] idx);
    flush_valid = v; flush_robidx_flag = fl; flush_robidx = idx;
  endtask

  task automatic set_enq(input logic v, input logic fl, input logic [ROB_SIZE_LOG-1:0] idx);
    enq_valid       = v;
    enq_robidx_flag = fl;
    enq_robidx      = idx;
    enq_prd         = PREG_W'($urandom_range(0, 127));
    enq_is_load     = 1'($urandom_range(0, 1));
    enq_is_store    = ~enq_is_load;
    enq_is_unsigned = 1'($urandom_range(0, 1));
    enq_imm         = {$urandom(), $urandom()};
    enq_src1        = {$urandom(), $urandom()};
    enq_src2        = {$urandom(), $urandom()};
    enq_ls_size     = LS_SIZE_W'(1 << $urandom_range(0, 3));
  endtask

  task automatic do_reset();
    idle_inputs();
    set_enq(1'b0, 1'b0, '0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic fill(input int n, input int first);
    for (int k = 0; k < n; k++) begin
      set_enq(1'b1, 1'b0, ROB_SIZE_LOG'(first + k));
      tick();
    end
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++;
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid: got %0b want 0", deq_valid); end
    n_checks++;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %0b want 1", enq_ready); end
    n_checks++;
    if (deq_src1 !== 64'd0) begin n_fail++; $display("FAIL reset_deq_fields: got %0h want 0", deq_src1); end
  endtask

  task automatic test_fill_drain();
    mem_iq_entry_t sent [4];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_enq(1'b1, 1'b0, ROB_SIZE_LOG'(k + 1));
      sent[k] = enq_view();
      tick();
    end
    enq_valid = 1'b0;
    settle();
    n_checks++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    n_checks++;
    if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_enq_ready: got %0b want 0", enq_ready); end
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++;
      if (deq_valid !== 1'b1 || deq_view() !== sent[k]) begin
        n_fail++;
        $display("FAIL drain_order: slot %0d got valid %0b robidx %0d want valid 1 robidx %0d",
                 k, deq_valid, deq_robidx, sent[k].robidx);
      end
      tick();
    end
    settle();
    n_checks++;
    if (deq_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL drain_empty: got valid %0b count %0d want 0 0", deq_valid, count);
    end
  endtask

  task automatic test_partial_flush();
    do_reset();
    fill(4, 1);
    set_flush(1'b1, 1'b0, 6'd2);
    tick();
    set_flush(1'b0, 1'b0, '0);
    settle();
    n_checks++;
    if (count !== 3'd2) begin n_fail++; $display("FAIL pflush_count: got %0d want 2", count); end
    deq_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      settle();
      n_checks++;
      if (deq_valid !== 1'b1 || deq_robidx !== ROB_SIZE_LOG'(k)) begin
        n_fail++; $display("FAIL pflush_deq: got valid %0b robidx %0d want 1 %0d", deq_valid, deq_robidx, k);
      end
      tick();
    end
    settle();
    n_checks++;
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL pflush_extra: got valid %0b robidx %0d want 0", deq_valid, deq_robidx); end
  endtask

  task automatic test_rob_wrap();
    do_reset();
    set_enq(1'b1, 1'b0, 6'd62); tick();
    set_enq(1'b1, 1'b1, 6'd0);  tick();
    enq_valid = 1'b0;
    set_flush(1'b1, 1'b0, 6'd62);
    tick();
    set_flush(1'b0, 1'b0, '0);
    settle();
    n_checks++;
    if (count !== 3'd1 || deq_robidx !== 6'd62 || deq_robidx_flag !== 1'b0) begin
      n_fail++; $display("FAIL rob_wrap: got count %0d head %0b/%0d want 1 0/62", count, deq_robidx_flag, deq_robidx);
    end
  endtask

  task automatic test_head_kill();
    do_reset();
    set_enq(1'b1, 1'b0, 6'd5); tick();
    deq_ready = 1'b1;
    set_flush(1'b1, 1'b0, 6'd3);
    set_enq(1'b1, 1'b0, 6'd4);
    settle();
    n_checks++;
    if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL head_kill_valid: got %0b want 0", deq_valid); end
    tick();
    set_flush(1'b0, 1'b0, '0);
    enq_valid = 1'b0;
    settle();
    n_checks++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL head_kill_count: got count %0d valid %0b want 0 0", count, deq_valid);
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    fill(3, 1);
    deq_ready = 1'b1;
    set_enq(1'b1, 1'b0, 6'd4);
    settle();
    n_checks++;
    if (deq_robidx !== 6'd1 || enq_ready !== 1'b1) begin
      n_fail++; $display("FAIL conc_head: got robidx %0d ready %0b want 1 1", deq_robidx, enq_ready);
    end
    tick();
    set_enq(1'b1, 1'b0, 6'd5);
    settle();
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL conc_count: got %0d want 3", count); end
    tick();
    enq_valid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      settle();
      n_checks++;
      if (deq_valid !== 1'b1 || deq_robidx !== ROB_SIZE_LOG'(k)) begin
        n_fail++; $display("FAIL conc_order: got valid %0b robidx %0d want 1 %0d", deq_valid, deq_robidx, k);
      end
      tick();
    end
    deq_ready = 1'b0;
    fill(4, 10);
    deq_ready = 1'b1;
    set_enq(1'b1, 1'b0, 6'd20);
    settle();
    n_checks++;
    if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_refuse_ready: got %0b want 0", enq_ready); end
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    settle();
    n_checks++;
    if (count !== 3'd3 || deq_robidx !== 6'd11) begin
      n_fail++; $display("FAIL full_refuse_count: got count %0d head %0d want 3 11", count, deq_robidx);
    end
  endtask

  task automatic test_random();
    mem_iq_entry_t q [$];
    mem_iq_entry_t e;
    logic [6:0] next_tag;
    logic [6:0] ft;
    logic       rst, ev, fv, exp_dv, exp_rdy;
    int         cut;
    do_reset();
    next_tag = 7'd120;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst     = ($urandom_range(0, 249) == 0);
      reset_n = ~rst;
      ev      = ($urandom_range(0, 99) < 60);
      set_enq(ev, next_tag[6], next_tag[5:0]);
      deq_ready = 1'($urandom_range(0, 1));
      fv = ($urandom_range(0, 99) < 12);
      ft = next_tag - 7'($urandom_range(0, 6));
      set_flush(fv, ft[6], ft[5:0]);
      settle();
      exp_rdy = (q.size() != DEPTH);
      exp_dv  = (q.size() != 0) && !(fv && younger_m(ft, {q[0].robidx_flag, q[0].robidx}));
      n_checks++;
      if (count !== (PTR_W+1)'(q.size())) begin
        n_fail++; $display("FAIL rand_count: cycle %0d got %0d want %0d", cyc, count, q.size());
      end
      n_checks++;
      if (enq_ready !== exp_rdy || deq_valid !== exp_dv) begin
        n_fail++; $display("FAIL rand_hs: cycle %0d got ready %0b valid %0b want %0b %0b",
                           cyc, enq_ready, deq_valid, exp_rdy, exp_dv);
      end
      if (exp_dv) begin
        n_checks++;
        if (deq_view() !== q[0]) begin
          n_fail++; $display("FAIL rand_head: cycle %0d got robidx %0d src1 %0h want robidx %0d src1 %0h",
                             cyc, deq_robidx, deq_src1, q[0].robidx, q[0].src1);
        end
      end
      e = enq_view();
      tick();
      if (rst) begin
        q.delete();
      end else begin
        if (fv) begin
          cut = q.size();
          for (int k = q.size() - 1; k >= 0; k--) begin
            if (younger_m(ft, {q[k].robidx_flag, q[k].robidx})) cut = k;
          end
          while (q.size() > cut) void'(q.pop_back());
        end
        if (exp_dv && deq_ready) void'(q.pop_front());
        if (ev && exp_rdy && !(fv && younger_m(ft, next_tag))) begin
          q.push_back(e);
          next_tag = next_tag + 7'd1;
        end
        if (fv) next_tag = ft + 7'd1;
      end
    end
    idle_inputs();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    set_enq(1'b0, 1'b0, '0);
    test_reset();
    test_fill_drain();
    test_partial_flush();
    test_rob_wrap();
    test_head_kill();
    test_concurrent();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
